// File: rtl/ntt_row_feeder.sv
// Buffers one N-word coefficient vector and replays it ROWS times in FRAME-beat rows with shift exponents.
// Optional NTT_FEEDER_PINGPONG_EN: two coefficient banks so the next vector loads while the current one streams.
module ntt_row_feeder #(
  parameter int N     = 64,
  parameter int FRAME = 72,
  parameter int ROWS  = 64,
  parameter int STEP  = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic [63:0] a,
  output logic [7:0]  w,
  output logic        frame_start,
  output logic        busy,
  output logic        done
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int JW = $clog2(FRAME + 1);
  localparam int KW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [7:0] STEP_M = 8'(STEP % 192);
`ifdef NTT_FEEDER_PINGPONG_EN
  localparam int AW = PW + 1;
`else
  localparam int AW = PW;
`endif

  typedef enum logic {LOAD, STREAM} state_t;

  state_t        state;
  logic [PW-1:0] wptr;
  logic [JW-1:0] j;
  logic [KW-1:0] k;
  logic [7:0]    wacc, delta;
  logic [63:0]   mem [2**AW];
  logic [AW-1:0] wr_addr, rd_addr;
  logic          accept, last_word, last_beat, last_row, start, chain, ready_n;

  // (x + d) mod 192 for x, d < 192 without ever leaving 8 bits
  function automatic logic [7:0] add_mod(input logic [7:0] x, input logic [7:0] d);
    logic [7:0] room;
    room = 8'd192 - d;
    return (x >= room) ? x - room : x + d;
  endfunction

  assign accept    = in_valid & in_ready;
  assign last_word = accept && (wptr == PW'(N - 1));
  assign last_beat = (j == JW'(FRAME - 1));
  assign last_row  = (k == KW'(ROWS - 1));

`ifdef NTT_FEEDER_PINGPONG_EN
  logic [1:0] full, full_n;
  logic       wbank, rbank, wbank_n;

  assign wr_addr = {wbank, wptr};
  assign rd_addr = {rbank, j[PW-1:0]};
  assign start   = (state == LOAD) && (full[rbank] || (last_word && wbank == rbank));
  assign chain   = full[~rbank] || (last_word && wbank != rbank);

  always_comb begin
    full_n  = full;
    wbank_n = wbank;
    if (state == STREAM && last_beat && last_row) full_n[rbank] = 1'b0;
    if (last_word) begin
      full_n[wbank] = 1'b1;
      wbank_n       = ~wbank;
    end
    ready_n = !full_n[wbank_n];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full  <= '0;
      wbank <= 1'b0;
      rbank <= 1'b0;
    end else begin
      full  <= full_n;
      wbank <= wbank_n;
      if (state == STREAM && last_beat && last_row) rbank <= ~rbank;
    end
  end
`else
  assign wr_addr = AW'(wptr);
  assign rd_addr = AW'(j[PW-1:0]);
  assign start   = (state == LOAD) && last_word;
  assign chain   = 1'b0;
  assign ready_n = (state == LOAD) && !last_word;
`endif

  always_ff @(posedge clk) begin
    if (accept) mem[wr_addr] <= in_data;
  end

  // Counters run one beat ahead of the registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD;
      wptr        <= '0;
      j           <= '0;
      k           <= '0;
      wacc        <= '0;
      delta       <= '0;
      a           <= '0;
      w           <= '0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      in_ready    <= 1'b0;
    end else begin
      in_ready    <= ready_n;
      busy        <= (state == STREAM);
      frame_start <= (state == STREAM) && (j == '0);
      done        <= (state == STREAM) && last_beat && last_row;
      if (accept) wptr <= last_word ? '0 : wptr + PW'(1);
      if (state == STREAM && j < JW'(N)) begin
        a <= mem[rd_addr];
        w <= wacc;
      end else begin
        a <= '0;
        w <= '0;
      end
      case (state)
        LOAD: begin
          if (start) begin
            state <= STREAM;
            j     <= '0;
            k     <= '0;
            wacc  <= '0;
            delta <= '0;
          end
        end
        STREAM: begin
          if (last_beat) begin
            j    <= '0;
            wacc <= '0;
            if (last_row) begin
              k     <= '0;
              delta <= '0;
              if (!chain) state <= LOAD;
            end else begin
              k     <= k + KW'(1);
              delta <= add_mod(delta, STEP_M);
            end
          end else begin
            j    <= j + JW'(1);
            wacc <= add_mod(wacc, delta);
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_ntt_row_feeder.sv
// Scoreboard bench for ntt_row_feeder: expected beats queued at load completion, popped as busy beats appear.
module tb_ntt_row_feeder;
  localparam int N = 64, FRAME = 72, ROWS = 64, STEP = 3;

  logic        clk = 0, rst_n = 0, in_valid = 0;
  logic [63:0] in_data = '0;
  logic        in_ready, frame_start, busy, done;
  logic [63:0] a;
  logic [7:0]  w;

  ntt_row_feeder #(.N(N), .FRAME(FRAME), .ROWS(ROWS), .STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .a(a), .w(w), .frame_start(frame_start), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [7:0]  w;
    logic        fs, dn;
    int          k, j;
  } exp_t;

  exp_t        sbq[$];
  logic [63:0] vec [N];
  int          n_chk = 0, n_pass = 0;
  int          mon_k = -1, mon_j = -1, cyc = 0;
  int          fs_times[$];
  logic        prev_done = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic push_vec();
    exp_t e;
    for (int kk = 0; kk < ROWS; kk++)
      for (int jj = 0; jj < FRAME; jj++) begin
        e.a  = (jj < N) ? vec[jj] : 64'd0;
        e.w  = (jj < N) ? 8'((kk * jj * STEP) % 192) : 8'd0;
        e.fs = (jj == 0);
        e.dn = (kk == ROWS - 1) && (jj == FRAME - 1);
        e.k  = kk;
        e.j  = jj;
        sbq.push_back(e);
      end
  endtask

  // Called at posedge+1; returns at posedge+1 after the last accepted word
  task automatic load(input int first, input int last_x, input bit rnd);
    int   i = first, guard = 0;
    logic acc;
    while (i < last_x && guard < 5000) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = in_valid ? vec[i] : {$urandom, $urandom};
      acc      = in_valid && in_ready;
      if (acc && i == N - 1) push_vec();
      @(posedge clk);
      #1;
      if (acc) i++;
      guard++;
    end
    in_valid = 0;
    chk("load_words", 128'(i), 128'(last_x));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sbq.size() != 0 || busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("stream_end_bound", 128'(n < 20000), 128'(1));
  endtask

  task automatic fill_rand();
    for (int i = 0; i < N; i++) vec[i] = {$urandom, $urandom};
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (busy) begin
      if (sbq.size() == 0) chk("unexpected_beat", 128'(1), 128'(0));
      else begin
        e = sbq.pop_front();
        chk("beat", 128'({a, w, frame_start, done}), 128'({e.a, e.w, e.fs, e.dn}));
        mon_k = e.k;
        mon_j = e.j;
        if (frame_start && e.k == 0) fs_times.push_back(cyc);
        if (e.k == 1 && e.j == 63) chk("w_r1_b63", 128'(w), 128'(189));
        if (e.k == 5 && e.j == 63) chk("w_r5_b63", 128'(w), 128'(177));
        if (e.k == 63 && e.j == 63) chk("w_r63_b63", 128'(w), 128'(3));
        if (e.k == 63 && e.j == 64) chk("w_r63_b64", 128'(w), 128'(0));
      end
`ifndef NTT_FEEDER_PINGPONG_EN
      chk("ready_low_in_stream", 128'(in_ready), 128'(0));
`endif
    end else begin
      chk("idle_zero", 128'({a, w, frame_start, done}), 128'(0));
    end
`ifndef NTT_FEEDER_PINGPONG_EN
    if (prev_done && rst_n) begin
      chk("busy_after_done", 128'(busy), 128'(0));
      chk("ready_after_done", 128'(in_ready), 128'(1));
    end
`endif
    prev_done = done;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    // reset and release
    repeat (3) @(negedge clk);
    chk("rst_outputs", 128'({a, w, frame_start, busy, done, in_ready}), 128'(0));
    rst_n = 1;
    #1 chk("ready_before_edge", 128'(in_ready), 128'(0));
    @(negedge clk);
    chk("ready_after_edge", 128'(in_ready), 128'(1));

    // ramp vector, exact first-frame latency
    for (int i = 0; i < N; i++) vec[i] = 64'(i + 1);
    @(posedge clk); #1;
    load(0, N, 0);
    @(negedge clk);
    chk("fs_at_E", 128'(frame_start), 128'(0));
`ifndef NTT_FEEDER_PINGPONG_EN
    chk("ready_drop_at_E", 128'(in_ready), 128'(0));
`endif
    @(negedge clk);
    chk("first_beat", 128'({frame_start, a, w}), 128'({1'b1, 64'd1, 8'd0}));
    wait_idle();

`ifndef NTT_FEEDER_PINGPONG_EN
    // in_valid held during stream must be ignored
    fill_rand();
    @(posedge clk); #1;
    load(0, N, 0);
    in_valid = 1;
    in_data  = '1;
    n = 0;
    while (!done && n < 6000) begin
      @(negedge clk);
      n++;
    end
    in_valid = 0;
    chk("done_seen", 128'(done), 128'(1));
    wait_idle();
`endif

    // gappy handshake load
    fill_rand();
    @(posedge clk); #1;
    load(0, N, 1);
    wait_idle();

    // asynchronous reset mid-stream, then partial reload
    fill_rand();
    @(posedge clk); #1;
    load(0, N, 0);
    n = 0;
    while (!(mon_k == 10 && mon_j == 20) && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("reach_r10_b20", 128'(n < 2000), 128'(1));
    rst_n = 0;
    #1 chk("rst_async", 128'({a, w, busy}), 128'(0));
    sbq.delete();
    mon_k = -1;
    repeat (3) @(negedge clk);
    rst_n = 1;
    fill_rand();
    @(posedge clk); #1;
    load(0, N - 1, 1);
    repeat (20) @(negedge clk);
    chk("no_stream_63", 128'(busy), 128'(0));
    @(posedge clk); #1;
    load(N - 1, N, 0);
    wait_idle();

`ifdef NTT_FEEDER_PINGPONG_EN
    // back-to-back vectors: B loads during A's stream
    fs_times.delete();
    fill_rand();
    @(posedge clk); #1;
    load(0, N, 0);
    fill_rand();
    load(0, N, 0);
    wait_idle();
    chk("pp_stream_count", 128'(fs_times.size()), 128'(2));
    if (fs_times.size() >= 2)
      chk("pp_gap", 128'(fs_times[1] - fs_times[0]), 128'(ROWS * FRAME));
`endif

    chk("sbq_empty", 128'(sbq.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
